step_gen_multi: RTL

//  Multi-channel stepper pulse generator; parametrised successor of the single-channel clock divider.
//  Per channel: emits a programmed number of 50%-duty step pulses at a programmed divider ratio.

---
 rtl/step_gen_pkg.sv | 15 +
 rtl/step_gen_multi_if.sv | 47 ++++
 rtl/step_gen_ch.sv | 162 ++++++++++++++++
 rtl/step_gen_multi.sv | 63 ++++++
 4 files changed

// File: rtl/step_gen_pkg.sv
// Shared types and default widths for the multi-channel step pulse generator.
package step_gen_pkg;

  localparam int unsigned NUM_CH_DEF = 4;
  localparam int unsigned DIV_W_DEF  = 32;
  localparam int unsigned CNT_W_DEF  = 31;
  localparam int unsigned POS_W_DEF  = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } step_state_e;

endpackage

// File: rtl/step_gen_multi_if.sv
// Control/status bundle between the register bridge and step_gen_multi.
// Position signals exist only when STEP_GEN_POSITION_EN is defined.
interface step_gen_multi_if
  import step_gen_pkg::*;
#(
  parameter int unsigned NUM_CH = NUM_CH_DEF,
  parameter int unsigned DIV_W  = DIV_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
`ifdef STEP_GEN_POSITION_EN
  ,
  parameter int unsigned POS_W  = POS_W_DEF
`endif
);

  logic [NUM_CH-1:0]       start;
  logic [NUM_CH-1:0]       abort;
  logic [NUM_CH*DIV_W-1:0] reduction;
  logic [NUM_CH*CNT_W-1:0] count;
  logic [NUM_CH-1:0]       dir_in;
  logic [NUM_CH-1:0]       step_out;
  logic [NUM_CH-1:0]       dir_out;
  logic [NUM_CH-1:0]       busy;
  logic [NUM_CH-1:0]       done;
`ifdef STEP_GEN_POSITION_EN
  logic [NUM_CH*POS_W-1:0] pos;
  logic [NUM_CH-1:0]       pos_clr;
`endif

  modport master (
    output start, abort, reduction, count, dir_in,
`ifdef STEP_GEN_POSITION_EN
    output pos_clr,
    input  pos,
`endif
    input  step_out, dir_out, busy, done
  );

  modport slave (
    input  start, abort, reduction, count, dir_in,
`ifdef STEP_GEN_POSITION_EN
    input  pos_clr,
    output pos,
`endif
    output step_out, dir_out, busy, done
  );

endinterface

// File: rtl/step_gen_ch.sv
// One step channel: IDLE/HIGH/LOW FSM, phase timer, step counter and, with
// STEP_GEN_POSITION_EN, a signed position counter.
module step_gen_ch
  import step_gen_pkg::*;
#(
  parameter int unsigned DIV_W = DIV_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
`ifdef STEP_GEN_POSITION_EN
  ,
  parameter int unsigned POS_W = POS_W_DEF
`endif
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic [DIV_W-1:0] reduction,
  input  logic [CNT_W-1:0] count,
  input  logic             dir_in,
  output logic             step_out,
  output logic             dir_out,
  output logic             busy,
  output logic             done
`ifdef STEP_GEN_POSITION_EN
  ,
  input  logic             pos_clr,
  output logic [POS_W-1:0] pos
`endif
);

  step_state_e      state_q, state_d;
  logic [DIV_W-1:0] timer_q, timer_d;
  logic [DIV_W-1:0] reload_q, reload_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             step_q, step_d;
  logic             dir_q, dir_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [DIV_W-1:0] reload_in;

  // Timer counts R-1 down to 0, with reduction=0 behaving as R=1.
  assign reload_in = (reduction == '0) ? '0 : reduction - DIV_W'(1);

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    reload_d = reload_q;
    cnt_d    = cnt_q;
    step_d   = step_q;
    dir_d    = dir_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          if (count != '0) begin
            reload_d = reload_in;
            timer_d  = reload_in;
            cnt_d    = count;
            dir_d    = dir_in;
            step_d   = 1'b1;
            busy_d   = 1'b1;
            state_d  = ST_HIGH;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_HIGH: begin
        if (abort) begin
          step_d  = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (timer_q == '0) begin
          step_d  = 1'b0;
          timer_d = reload_q;
          cnt_d   = cnt_q - CNT_W'(1);
          state_d = ST_LOW;
        end else begin
          timer_d = timer_q - DIV_W'(1);
        end
      end
      ST_LOW: begin
        if (abort) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (timer_q == '0) begin
          if (cnt_q == '0) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            step_d  = 1'b1;
            timer_d = reload_q;
            state_d = ST_HIGH;
          end
        end else begin
          timer_d = timer_q - DIV_W'(1);
        end
      end
      default: begin
        step_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      timer_q  <= '0;
      reload_q <= '0;
      cnt_q    <= '0;
      step_q   <= 1'b0;
      dir_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      reload_q <= reload_d;
      cnt_q    <= cnt_d;
      step_q   <= step_d;
      dir_q    <= dir_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign step_out = step_q;
  assign dir_out  = dir_q;
  assign busy     = busy_q;
  assign done     = done_q;

`ifdef STEP_GEN_POSITION_EN
  logic [POS_W-1:0] pos_q, pos_d;

  // A rising step_out edge is exactly step_d=1 while step_q=0; dir_d is the move's direction.
  always_comb begin
    pos_d = pos_q;
    if (pos_clr) begin
      pos_d = '0;
    end else if (step_d && !step_q) begin
      pos_d = dir_d ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pos_q <= '0;
    end else begin
      pos_q <= pos_d;
    end
  end

  assign pos = pos_q;
`endif

endmodule

// File: rtl/step_gen_multi.sv
// Multi-channel stepper pulse generator: NUM_CH independent step_gen_ch instances.
// Optional position counters are enabled by defining STEP_GEN_POSITION_EN.
module step_gen_multi
  import step_gen_pkg::*;
#(
  parameter int unsigned NUM_CH = NUM_CH_DEF,
  parameter int unsigned DIV_W  = DIV_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
`ifdef STEP_GEN_POSITION_EN
  ,
  parameter int unsigned POS_W  = POS_W_DEF
`endif
) (
  input logic             clk,
  input logic             reset_n,
  step_gen_multi_if.slave bus
);

  logic [NUM_CH-1:0] step_w;
  logic [NUM_CH-1:0] dir_w;
  logic [NUM_CH-1:0] busy_w;
  logic [NUM_CH-1:0] done_w;
`ifdef STEP_GEN_POSITION_EN
  logic [NUM_CH*POS_W-1:0] pos_w;
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    step_gen_ch #(
      .DIV_W (DIV_W),
      .CNT_W (CNT_W)
`ifdef STEP_GEN_POSITION_EN
      ,
      .POS_W (POS_W)
`endif
    ) u_ch (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (bus.start[i]),
      .abort     (bus.abort[i]),
      .reduction (bus.reduction[i*DIV_W +: DIV_W]),
      .count     (bus.count[i*CNT_W +: CNT_W]),
      .dir_in    (bus.dir_in[i]),
      .step_out  (step_w[i]),
      .dir_out   (dir_w[i]),
      .busy      (busy_w[i]),
      .done      (done_w[i])
`ifdef STEP_GEN_POSITION_EN
      ,
      .pos_clr   (bus.pos_clr[i]),
      .pos       (pos_w[i*POS_W +: POS_W])
`endif
    );
  end

  assign bus.step_out = step_w;
  assign bus.dir_out  = dir_w;
  assign bus.busy     = busy_w;
  assign bus.done     = done_w;
`ifdef STEP_GEN_POSITION_EN
  assign bus.pos      = pos_w;
`endif

endmodule
